// File: rtl/spi_cfg_pkg.sv
// Shared frame layout for the 24-bit SPI configuration link.
// Used by the responder RTL and by the clock-init script tools.
package spi_cfg_pkg;

  localparam int FrmLen = 24;
  localparam int RnwBit = 23;
  localparam int AdrMsb = 22;
  localparam int AdrLsb = 8;
  localparam int DatMsb = 7;
  localparam int CntW   = 5;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

endpackage

// File: rtl/spi_slv_sync.sv
// Pin synchronizer with edge pulses for the SPI responder.
// Pulses are held off until the chain holds only real pin samples.
module spi_slv_sync #(
  parameter int   SyncLen = 2,
  parameter logic RstVal  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncLen-1:0] sync_q;
  logic [SyncLen:0]   vld_q;
  logic               dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SyncLen{RstVal}};
      dly_q  <= RstVal;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncLen-2:0], d_i};
      dly_q  <= sync_q[SyncLen-1];
      vld_q  <= {vld_q[SyncLen-1:0], 1'b1};
    end
  end

  assign lvl_o  = sync_q[SyncLen-1];
  assign rise_o = vld_q[SyncLen] & lvl_o & ~dly_q;
  assign fall_o = vld_q[SyncLen] & ~lvl_o & dly_q;

endmodule

// File: rtl/spi_cfg_slave.sv
// Mode-3 SPI configuration responder with a byte register file.
// Frame = {rnw, adr[14:0], dat[7:0]}, MSB first.
import spi_cfg_pkg::*;

module spi_cfg_slave #(
  parameter int AdrWid  = 6,
  parameter int SyncLen = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csb,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_stb,
  output logic [AdrWid-1:0] wr_adr,
  output logic [7:0]        wr_dat,
  input  logic [AdrWid-1:0] rd_adr,
  output logic [7:0]        rd_dat,
  output logic              err_abort
);

  localparam int Depth = 1 << AdrWid;
  localparam int RdRnw = RnwBit - AdrLsb;
  localparam logic [CntW-1:0] CntRd  = CntW'(RdRnw);
  localparam logic [CntW-1:0] CntFrm = CntW'(FrmLen);

  logic csb_lvl, csb_rise, csb_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_lvl;

  spi_slv_sync #(.SyncLen(SyncLen), .RstVal(1'b1)) u_csb (
    .clk(clk), .rst_n(rst_n), .d_i(csb),
    .lvl_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall)
  );

  spi_slv_sync #(.SyncLen(SyncLen), .RstVal(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_slv_sync #(.SyncLen(SyncLen), .RstVal(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi),
    .lvl_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_lvl = ^{csb_lvl, sclk_lvl, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [FrmLen-1:0]   sr_q, sr_d, sr_nx;
  logic [7:0]          tx_q, tx_d;
  logic                pend_q, pend_d;
  logic                oe_q, oe_d;
  logic                miso_q, miso_d;
  logic                stb_q, stb_d;
  logic                err_q, err_d;
  logic [AdrWid-1:0]   wadr_q, wadr_d;
  logic [7:0]          wdat_q, wdat_d;
  logic [7:0]          rdd_q;
  logic                we;
  logic [7:0]          mem_q [Depth];

  assign sr_nx = {sr_q[FrmLen-2:0], mosi_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    pend_d  = pend_q;
    oe_d    = oe_q;
    miso_d  = miso_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      ST_SHIFT: begin
        if (csb_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          pend_d  = 1'b0;
          if (cnt_q != CntFrm) begin
            err_d = 1'b1;
          end else if (!sr_q[RnwBit] &&
                       sr_q[AdrMsb:AdrLsb+AdrWid] == '0) begin
            we     = 1'b1;
            stb_d  = 1'b1;
            wadr_d = sr_q[AdrLsb+AdrWid-1:AdrLsb];
            wdat_d = sr_q[DatMsb:0];
          end
        end else begin
          if (sclk_rise) begin
            sr_d = sr_nx;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntRd && sr_nx[RdRnw]) begin
              pend_d = 1'b1;
              tx_d   = (sr_nx[RdRnw-1:AdrWid] == '0) ?
                       mem_q[sr_nx[AdrWid-1:0]] : 8'h00;
            end
          end
          // Drive only on falls so miso is settled at the master's rise.
          if (sclk_fall && (pend_q || oe_q)) begin
            oe_d   = 1'b1;
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tx_q    <= '0;
      pend_q  <= 1'b0;
      oe_q    <= 1'b0;
      miso_q  <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= '0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      pend_q  <= pend_d;
      oe_q    <= oe_d;
      miso_q  <= miso_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
      rdd_q   <= mem_q[rd_adr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wadr_d] <= wdat_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign wr_stb    = stb_q;
  assign wr_adr    = wadr_q;
  assign wr_dat    = wdat_q;
  assign rd_dat    = rdd_q;
  assign err_abort = err_q;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Scoreboard bench for spi_cfg_slave: mode-3 master, clk_div 16.
// Write/error events are queued by stimulus and checked by a monitor.
module tb_spi_cfg_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       csb = 1'b1;
  logic       sclk = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_stb, err_abort;
  logic [5:0] wr_adr, rd_adr;
  logic [7:0] wr_dat, rd_dat;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       err;
    logic [5:0] adr;
    logic [7:0] dat;
  } evt_t;

  evt_t sbq[$];

  always #5 clk = ~clk;

  spi_cfg_slave #(.AdrWid(6), .SyncLen(2)) dut (
    .clk(clk), .rst_n(rst_n), .csb(csb), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_stb(wr_stb),
    .wr_adr(wr_adr), .wr_dat(wr_dat), .rd_adr(rd_adr),
    .rd_dat(rd_dat), .err_abort(err_abort)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [23:0] frm, input int nbits,
                          input int rst_bit, output logic [23:0] cap,
                          output logic [23:0] oe);
    cap = '0;
    oe  = '0;
    @(negedge clk);
    csb = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = frm[23-i];
      if (i == rst_bit) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (8) @(negedge clk);
      cap  = {cap[22:0], miso};
      oe   = {oe[22:0], miso_oe};
      sclk = 1'b1;
      repeat (8) @(negedge clk);
    end
    csb = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    logic [23:0] c, o;
    evt_t e;
    e.err = 1'b0;
    e.adr = a;
    e.dat = d;
    sbq.push_back(e);
    spi_xfer({1'b0, 9'd0, a, d}, 24, -1, c, o);
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a,
                        input logic [7:0] exp);
    rd_adr = a;
    @(negedge clk);
    @(negedge clk);
    chk(nm, {24'd0, rd_dat}, {24'd0, exp});
  endtask

  initial begin
    logic [23:0] cap, oe;
    evt_t e;
    rd_adr = '0;

    fork
      forever begin
        @(negedge clk);
        if (wr_stb || err_abort) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got stb=%0b err=%0b adr=%0h expected none",
                     wr_stb, err_abort, wr_adr);
          end else begin
            e = sbq.pop_front();
            chk("evt_err", {31'd0, err_abort}, {31'd0, e.err});
            chk("evt_stb", {31'd0, wr_stb}, {31'd0, ~e.err});
            if (!e.err) begin
              chk("evt_adr", {26'd0, wr_adr}, {26'd0, e.adr});
              chk("evt_dat", {24'd0, wr_dat}, {24'd0, e.dat});
            end
          end
        end
      end
    join_none

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_wadr", {26'd0, wr_adr}, 32'd0);
    chk("rst_wdat", {24'd0, wr_dat}, 32'd0);
    chk("rst_err", {31'd0, err_abort}, 32'd0);
    rd_chk("rst_rd", 6'h12, 8'h00);

    wr(6'h12, 8'h34);
    rd_chk("rd_12", 6'h12, 8'h34);

    spi_xfer(24'h801200, 24, -1, cap, oe);
    chk("read_dat", {24'd0, cap[7:0]}, 32'h34);
    chk("read_oe", {8'd0, oe}, 32'h0000ff);

    e.err = 1'b1;
    e.adr = '0;
    e.dat = '0;
    sbq.push_back(e);
    spi_xfer(24'h001299, 10, -1, cap, oe);
    rd_chk("abort_keep", 6'h12, 8'h34);
    wr(6'h0a, 8'h77);
    rd_chk("after_abort", 6'h0a, 8'h77);

    spi_xfer(24'h004055, 24, -1, cap, oe);
    rd_chk("oor_alias", 6'h00, 8'h00);
    spi_xfer(24'h804000, 24, -1, cap, oe);
    chk("oor_read", {24'd0, cap[7:0]}, 32'h00);
    chk("oor_oe", {8'd0, oe}, 32'h0000ff);

    spi_xfer(24'h000977, 24, 12, cap, oe);
    rd_chk("rst_mid_09", 6'h09, 8'h00);
    rd_chk("rst_clear", 6'h12, 8'h00);
    wr(6'h05, 8'h01);
    rd_chk("post_rst", 6'h05, 8'h01);

    for (int i = 0; i < 64; i++) wr(6'(i), ~8'(i));
    for (int i = 0; i < 64; i++) rd_chk("bulk_rd", 6'(i), ~8'(i));

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
